// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes and debounces channels A/B, then emits
// one-cycle count pulses with direction for an up/down counter (x4 decoding).
module quad_decoder #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic CLK,
  input  logic CDN,
  input  logic A,
  input  logic B,
  input  logic EN,
  input  logic ERRCLR,
  output logic CNT_EN,
  output logic DNUP,
  output logic ERR,
  output logic LOCKED
);

  localparam logic [3:0] FILT_MAX = 4'(FILT_LEN);

  typedef enum logic {
    INIT,
    TRACK
  } state_e;

  state_e state_q, state_d;

  logic [1:0]      meta_q, sync_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic [3:0]      stab_q, stab_d;
  logic [1:0]      prev_q, prev_d;
  logic            cntEn_q, cntEn_d;
  logic            dnUp_q, dnUp_d;
  logic            err_q, err_d;
  logic            locked_q, locked_d;
  logic            lockReady;
  logic [1:0]      step;

  // Gray position along the up sequence 00->01->11->10.
  function automatic logic [1:0] grayPos(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Per-channel debounce; bit 1 is A, bit 0 is B.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] == filt_q[i]) begin
        fcnt_d[i] = '0;
      end else if (fcnt_q[i] + 4'd1 == FILT_MAX) begin
        filt_d[i] = sync_q[i];
        fcnt_d[i] = '0;
      end else begin
        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end
    end
  end

  // Counts edges on which the synchronized pair did not change.
  always_comb begin
    if (meta_q != sync_q) begin
      stab_d = '0;
    end else if (stab_q >= FILT_MAX) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 4'd1;
    end
  end

  assign lockReady = (fcnt_q[1] == 4'd0) && (fcnt_q[0] == 4'd0) && (stab_q >= FILT_MAX);
  assign step      = grayPos(filt_q) - grayPos(prev_q);

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      INIT:    if (lockReady) state_d = TRACK;
      TRACK:   state_d = TRACK;
      default: state_d = INIT;
    endcase
  end

  // A step of two positions means both channels moved at once.
  always_comb begin
    cntEn_d  = 1'b0;
    dnUp_d   = dnUp_q;
    err_d    = err_q & ~ERRCLR;
    locked_d = locked_q;
    prev_d   = prev_q;
    case (state_q)
      INIT: begin
        locked_d = 1'b0;
        if (lockReady) begin
          prev_d   = sync_q;
          locked_d = 1'b1;
        end
      end
      TRACK: begin
        prev_d = filt_q;
        case (step)
          2'd1: begin
            cntEn_d = EN;
            dnUp_d  = 1'b0;
          end
          2'd3: begin
            cntEn_d = EN;
            dnUp_d  = 1'b1;
          end
          2'd2: err_d = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge CDN) begin
    if (!CDN) begin
      meta_q   <= '0;
      sync_q   <= '0;
      filt_q   <= '0;
      fcnt_q   <= '0;
      stab_q   <= '0;
      prev_q   <= '0;
      cntEn_q  <= 1'b0;
      dnUp_q   <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      meta_q   <= {A, B};
      sync_q   <= meta_q;
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      stab_q   <= stab_d;
      prev_q   <= prev_d;
      cntEn_q  <= cntEn_d;
      dnUp_q   <= dnUp_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  assign CNT_EN = cntEn_q;
  assign DNUP   = dnUp_q;
  assign ERR    = err_q;
  assign LOCKED = locked_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Self-checking bench for quad_decoder: expected count pulses are queued when
// channel levels are driven and matched against CNT_EN/DNUP as they appear.
module tb_quad_decoder;

  localparam int FILT_LEN = 3;
  localparam int LAT      = FILT_LEN + 2;

  logic CLK = 1'b0;
  logic CDN, A, B, EN, ERRCLR;
  logic CNT_EN, DNUP, ERR, LOCKED;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int   cycle;
    logic dir;
  } ExpPulse;

  ExpPulse    expQ[$];
  ExpPulse    got;
  logic [1:0] modelAB = 2'b00;

  quad_decoder #(.FILT_LEN(FILT_LEN)) dut (
    .CLK   (CLK),
    .CDN   (CDN),
    .A     (A),
    .B     (B),
    .EN    (EN),
    .ERRCLR(ERRCLR),
    .CNT_EN(CNT_EN),
    .DNUP  (DNUP),
    .ERR   (ERR),
    .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  function automatic logic [1:0] upNext(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b01;
      2'b01:   return 2'b11;
      2'b11:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] downNext(input logic [1:0] g);
    case (g)
      2'b00:   return 2'b10;
      2'b10:   return 2'b11;
      2'b11:   return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Every pulse seen must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (CDN === 1'b1 && CNT_EN !== 1'b0) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpectedPulse", {31'd0, CNT_EN}, 32'd0);
      end else begin
        got = expQ.pop_front();
        checkOutput("pulseCycle", cyc, got.cycle);
        checkOutput("pulseDir", {31'd0, DNUP}, {31'd0, got.dir});
      end
    end
  end

  // Called at a negedge; the level is first sampled on the next posedge.
  task automatic applyStimulus(input logic a, input logic b, input int hold);
    logic [1:0] nxt;
    nxt = {a, b};
    A = a;
    B = b;
    if (nxt != modelAB) begin
      if (nxt == upNext(modelAB)) begin
        if (EN) expQ.push_back('{cyc + 1 + LAT, 1'b0});
      end else if (nxt == downNext(modelAB)) begin
        if (EN) expQ.push_back('{cyc + 1 + LAT, 1'b1});
      end
      modelAB = nxt;
    end
    repeat (hold) @(negedge CLK);
  endtask

  task automatic applyGlitch(input logic a, input logic b, input int len);
    A = a;
    B = b;
    repeat (len) @(negedge CLK);
    A = modelAB[1];
    B = modelAB[0];
    repeat (10) @(negedge CLK);
  endtask

  task automatic settle();
    repeat (12) @(negedge CLK);
    checkOutput("pendingPulses", expQ.size(), 32'd0);
    expQ.delete();
  endtask

  task automatic doReset(input logic a, input logic b, input int maxWait);
    int waited;
    #2;
    CDN = 1'b0;
    #1;
    checkOutput("rstCntEn", {31'd0, CNT_EN}, 32'd0);
    checkOutput("rstDnUp", {31'd0, DNUP}, 32'd0);
    checkOutput("rstErr", {31'd0, ERR}, 32'd0);
    checkOutput("rstLocked", {31'd0, LOCKED}, 32'd0);
    expQ.delete();
    A = a;
    B = b;
    modelAB = {a, b};
    repeat (2) @(negedge CLK);
    CDN = 1'b1;
    waited = 0;
    while (LOCKED !== 1'b1 && waited < maxWait) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("lockAfterReset", {31'd0, LOCKED}, 32'd1);
    checkOutput("errAfterLock", {31'd0, ERR}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    CDN = 1'b0;
    A = 1'b1;
    B = 1'b1;
    EN = 1'b1;
    ERRCLR = 1'b0;
    @(negedge CLK);

    // Power-up with 11 held: lock must come within 6 cycles, without pulses.
    doReset(1'b1, 1'b1, 6);
    settle();

    // Full up cycle from 00.
    doReset(1'b0, 1'b0, 20);
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 8);
    settle();

    // Down steps, reversals in both directions.
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 8);
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b0, 1'b0, 8);
    settle();

    // A 2-cycle glitch is filtered; a 3-cycle one produces two pulses.
    applyGlitch(1'b1, 1'b0, FILT_LEN - 1);
    settle();
    checkOutput("errGlitch", {31'd0, ERR}, 32'd0);
    applyStimulus(1'b1, 1'b0, FILT_LEN);
    applyStimulus(1'b0, 1'b0, 8);
    settle();
    checkOutput("errShortPulse", {31'd0, ERR}, 32'd0);

    // Walk down to 01 (DNUP=1), then jump to 10.
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b1, 1'b1, 8);
    applyStimulus(1'b0, 1'b1, 8);
    settle();
    applyStimulus(1'b1, 1'b0, 8);
    checkOutput("errSet", {31'd0, ERR}, 32'd1);
    checkOutput("dnupHeld", {31'd0, DNUP}, 32'd1);
    settle();
    checkOutput("errSticky", {31'd0, ERR}, 32'd1);
    ERRCLR = 1'b1;
    @(negedge CLK);
    ERRCLR = 1'b0;
    checkOutput("errCleared", {31'd0, ERR}, 32'd0);

    // Illegal step detected on the very edge ERRCLR is sampled.
    A = 1'b0;
    B = 1'b1;
    modelAB = 2'b01;
    repeat (LAT) @(negedge CLK);
    checkOutput("errBeforeCoincident", {31'd0, ERR}, 32'd0);
    ERRCLR = 1'b1;
    @(negedge CLK);
    ERRCLR = 1'b0;
    checkOutput("errClrCoincident", {31'd0, ERR}, 32'd1);
    ERRCLR = 1'b1;
    @(negedge CLK);
    ERRCLR = 1'b0;
    settle();

    // EN gating: two silent up steps, then one counted.
    doReset(1'b0, 1'b0, 20);
    EN = 1'b0;
    applyStimulus(1'b0, 1'b1, 8);
    applyStimulus(1'b1, 1'b1, 8);
    EN = 1'b1;
    applyStimulus(1'b1, 1'b0, 8);
    settle();
    checkOutput("dnupAfterEnSteps", {31'd0, DNUP}, 32'd0);

    // Raise ERR, start a step, then reset before its pulse emerges.
    applyStimulus(1'b0, 1'b1, 8);
    checkOutput("errBeforeReset", {31'd0, ERR}, 32'd1);
    applyStimulus(1'b1, 1'b1, 2);
    doReset(1'b1, 1'b1, 20);
    settle();
    applyStimulus(1'b1, 1'b0, 8);
    settle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
